// File: rtl/load_store_multi_if.sv
// ----------------------------------------------------------------------------
// load_store_multi_if
// Bundles the control inputs and the per-channel status outputs of
// load_store_multi.
//   master : drives en/mode/lim_* and observes vol/dir/sig/peak/trough
//   slave  : the counter block itself
// Signals:
//   en       [CHANNELS]        per-channel step enable
//   mode     [CHANNELS]        0 = triangle, 1 = sawtooth
//   lim_we                     limit write strobe
//   lim_ch   [4]               limit write channel index
//   lim_data [CBITS]           new limit value
//   vol      [CHANNELS*CBITS]  channel i at [i*CBITS +: CBITS]
//   dir      [CHANNELS]        1 = counting up
//   sig      [CHANNELS]        vol == limit
//   peak     [CHANNELS]        rising edge of sig
//   trough   [CHANNELS]        vol just reached 0 from nonzero
// ----------------------------------------------------------------------------
interface load_store_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CBITS    = 15
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       mode;
    logic                      lim_we;
    logic [3:0]                lim_ch;
    logic [CBITS-1:0]          lim_data;
    logic [CHANNELS*CBITS-1:0] vol;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       sig;
    logic [CHANNELS-1:0]       peak;
    logic [CHANNELS-1:0]       trough;

    modport master (
        output en, mode, lim_we, lim_ch, lim_data,
        input  vol, dir, sig, peak, trough
    );

    modport slave (
        input  en, mode, lim_we, lim_ch, lim_data,
        output vol, dir, sig, peak, trough
    );
endinterface

// File: rtl/load_store_multi.sv
// ----------------------------------------------------------------------------
// load_store_multi
// CHANNELS independent up/down volume counters, each bounded by its own
// run-time programmable limit. Each channel runs in triangle (up, dwell,
// down, dwell) or sawtooth (up then wrap to 0) mode and reports level,
// peak and trough flags. All outputs are registered; flags are derived
// from the same-edge next values so they line up with vol.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : load_store_multi_if.slave (controls in, status out)
// ----------------------------------------------------------------------------
module load_store_multi #(
    parameter int CHANNELS  = 4,
    parameter int CBITS     = 15,
    parameter int N_DEFAULT = 22500
) (
    input  logic                clk,
    input  logic                rst,
    load_store_multi_if.slave   bus
);

    localparam logic [CBITS-1:0] ONE     = CBITS'(1);
    localparam logic [CBITS-1:0] LIM_RST = CBITS'(N_DEFAULT);

    logic [CBITS-1:0]    r_vol [CHANNELS];
    logic [CBITS-1:0]    r_lim [CHANNELS];
    logic [CHANNELS-1:0] r_dir;
    logic [CHANNELS-1:0] r_sig;
    logic [CHANNELS-1:0] r_peak;
    logic [CHANNELS-1:0] r_trough;

    logic [CBITS-1:0]    w_vol_nx [CHANNELS];
    logic [CBITS-1:0]    w_lim_nx [CHANNELS];
    logic [CHANNELS-1:0] w_dir_nx;
    logic [CHANNELS-1:0] w_wr;

    always_comb begin
        w_dir_nx = r_dir;
        w_wr     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_vol_nx[i] = r_vol[i];
            w_lim_nx[i] = r_lim[i];
            // Indices >= CHANNELS never match, so those writes fall away.
            w_wr[i] = bus.lim_we && (bus.lim_ch == 4'(i));
            if (w_wr[i]) begin
                // A write freezes the channel for one cycle; only clamp
                // vol back inside the new range if it now lies outside.
                w_lim_nx[i] = bus.lim_data;
                if (r_vol[i] > bus.lim_data) begin
                    if (bus.mode[i]) begin
                        w_vol_nx[i] = '0;
                    end else begin
                        w_vol_nx[i] = bus.lim_data;
                        w_dir_nx[i] = 1'b0;
                    end
                end
            end else if (bus.en[i]) begin
                if (bus.mode[i]) begin
                    w_dir_nx[i] = 1'b1;
                    w_vol_nx[i] = (r_vol[i] >= r_lim[i]) ? '0 : r_vol[i] + ONE;
                end else if (r_dir[i]) begin
                    // Turning around costs one cycle with vol held.
                    if (r_vol[i] >= r_lim[i]) w_dir_nx[i] = 1'b0;
                    else                      w_vol_nx[i] = r_vol[i] + ONE;
                end else begin
                    if (r_vol[i] == '0) w_dir_nx[i] = 1'b1;
                    else                w_vol_nx[i] = r_vol[i] - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_vol[i] <= '0;
                r_lim[i] <= LIM_RST;
            end
            r_dir    <= '0;
            r_sig    <= '0;
            r_peak   <= '0;
            r_trough <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_vol[i]    <= w_vol_nx[i];
                r_lim[i]    <= w_lim_nx[i];
                r_sig[i]    <= (w_vol_nx[i] == w_lim_nx[i]);
                r_peak[i]   <= (w_vol_nx[i] == w_lim_nx[i]) && !r_sig[i];
                r_trough[i] <= (w_vol_nx[i] == '0) && (r_vol[i] != '0);
            end
            r_dir <= w_dir_nx;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_vol
        assign bus.vol[g*CBITS +: CBITS] = r_vol[g];
    end

    assign bus.dir    = r_dir;
    assign bus.sig    = r_sig;
    assign bus.peak   = r_peak;
    assign bus.trough = r_trough;

endmodule

// File: doc/load_store_multi.md
Name: load_store_multi

Overview:
- Multi-channel, parametrised successor of the single triangle load/store volume counter.
- Each channel runs an independent up/down volume counter between 0 and a run-time programmable limit.
- Each channel supports per-channel enable and triangle/sawtooth mode, and reports peak, trough and direction.
- Used as the stimulus/occupancy generator for multi-port buffer models in the benchmark suite.

Parameters:
- CHANNELS, 4, number of independent counter channels (1..16).
- CBITS, 15, counter and limit width per channel.
- N_DEFAULT, 22500, reset value of every channel's limit register; must be < 2**CBITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  CHANNELS  per-channel step enable; bit i gates channel i.
- mode  input  CHANNELS  per-channel mode; 0 = triangle, 1 = sawtooth.
- lim_we  input  1  limit write strobe.
- lim_ch  input  4  channel index for the limit write; values >= CHANNELS are ignored.
- lim_data  input  CBITS  new limit value.
- vol  output  CHANNELS*CBITS  per-channel counter value; channel i occupies [i*CBITS +: CBITS].
- dir  output  CHANNELS  per-channel direction; 1 = up.
- sig  output  CHANNELS  level flag; set when vol_i == limit_i.
- peak  output  CHANNELS  one-cycle pulse on the cycle vol_i first becomes equal to limit_i.
- trough  output  CHANNELS  one-cycle pulse on the cycle vol_i first becomes 0 after being nonzero.

Behaviour:
- Reset:
  - every vol = 0, dir = 0, limit = N_DEFAULT, sig = 0, peak = 0, trough = 0.
  - rst overrides en, lim_we and mode in the same cycle.
  - Mid-run reset returns all channels to the reset state on the next edge.
- All outputs are registered. Flags are computed from the post-update vol/limit of the same edge, so there is zero extra latency relative to vol.
- Triangle step (en_i = 1, mode_i = 0, no limit write to channel i):
  - dir = 1: if vol >= limit, dir <= 0 and vol holds (one dwell cycle); else vol <= vol + 1.
  - dir = 0: if vol == 0, dir <= 1 and vol holds (one dwell cycle); else vol <= vol - 1.
  - Period = 2*(limit+1) cycles; sig is high for 2 consecutive cycles per period.
- Sawtooth step (en_i = 1, mode_i = 1):
  - if vol >= limit, vol <= 0; else vol <= vol + 1.
  - dir <= 1 every step; period = limit+1.
- Hold (en_i = 0): vol and dir are unchanged; sig is still recomputed against the current limit.
- Limit write (lim_we = 1, lim_ch = i < CHANNELS):
  - limit_i <= lim_data; channel i does not step this cycle, regardless of en_i.
  - If vol_i > lim_data: vol_i <= lim_data, and dir_i <= 0 in triangle mode or vol_i <= 0 in sawtooth mode.
  - Other channels step normally.
- limit = 0:
  - Triangle: vol stays 0, dir toggles every enabled cycle, sig constantly 1, peak never re-fires.
  - Sawtooth: vol stays 0, sig constantly 1.
- Pulses:
  - peak_i = sig_next & ~sig_current.
  - trough_i = (vol_next == 0) & (vol_current != 0).
  - Neither fires on the reset-release cycle.
- Mode change mid-run: takes effect at the next step; vol is not altered by the switch itself.
- Arithmetic: no wrap beyond 2**CBITS-1, guaranteed because limit < 2**CBITS; all compares are unsigned.

Test Plan:
- Reset, write limit 3 to ch0, mode 0, en0 = 1 continuous.
  -> vol0 sequence 0,0,1,2,3,3,2,1,0,0,1...
  -> sig0 high on both 3s; peak0 on the first 3 only; trough0 on the first 0 after the 1.
- ch1 limit 3, mode 1, en1 = 1.
  -> vol1 = 0,1,2,3,0,1,2,3...; peak1 every 4 cycles; dir1 = 1 throughout.
- ch0 counting up at vol 5 with limit 10, write limit 2 to ch0.
  -> next cycle vol0 = 2, dir0 = 0, sig0 = 1; then 1, 0, 0 (dwell), 1.
- en2 dropped at vol2 = 7 for 5 cycles.
  -> vol2 stays 7, dir2 unchanged; resumes at 8 (up) or 6 (down).
- Limit 0 on ch3, triangle mode.
  -> vol3 constant 0, dir3 toggles every cycle, sig3 = 1 continuously.
- Assert rst mid-count with lim_we = 1 in the same cycle.
  -> all vol = 0, dir = 0, limits = 22500, write discarded.
- Write with lim_ch = 15 when CHANNELS = 4.
  -> no limit changes; all channels keep stepping.
